// File: rtl/serial_mul_if.sv
// serial_mul_if: handshake/data bundle for the shift-add multiplier.
//   en     : stage enable (low = full stall)
//   clr    : synchronous abort/clear
//   start  : request a new multiply
//   a, b   : signed operands, sampled on the accepted start
//   busy   : multiply in progress
//   valid  : one-cycle pulse, prod just updated
//   prod   : registered signed product
// master = requester side, slave = multiplier side.
interface serial_mul_if #(
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 32
);
    logic                     en;
    logic                     clr;
    logic                     start;
    logic signed [IWIDTH-1:0] a;
    logic signed [IWIDTH-1:0] b;
    logic                     busy;
    logic                     valid;
    logic signed [OWIDTH-1:0] prod;

    modport master (
        output en, clr, start, a, b,
        input  busy, valid, prod
    );

    modport slave (
        input  en, clr, start, a, b,
        output busy, valid, prod
    );
endinterface

// File: rtl/serial_mul.sv
// serial_mul: signed shift-add multiplier, one multiplier bit per enabled
// cycle, LSB first. Feeds the PE accumulator with a registered product and a
// one-cycle valid strobe; one product every IWIDTH+1 cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_mul_if.slave (en, clr, start, a, b -> busy, valid, prod)
// OWIDTH must be at least 2*IWIDTH; the product is sign-extended to OWIDTH.
module serial_mul #(
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_mul_if.slave  bus
);
    localparam int PW = 2 * IWIDTH;
    localparam int CW = (IWIDTH > 1) ? $clog2(IWIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(IWIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                   state, state_nxt;
    logic signed [IWIDTH-1:0] a_q, a_nxt;
    logic        [IWIDTH-1:0] b_q, b_nxt;
    logic        [CW-1:0]     cnt_q, cnt_nxt;
    logic signed [PW-1:0]     part_q, part_nxt;
    logic signed [OWIDTH-1:0] prod_q, prod_nxt;
    logic                     valid_q, valid_nxt;

    logic signed [PW-1:0]     term;
    logic signed [PW-1:0]     sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            part_q  <= '0;
            prod_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            cnt_q   <= cnt_nxt;
            part_q  <= part_nxt;
            prod_q  <= prod_nxt;
            valid_q <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        cnt_nxt   = cnt_q;
        part_nxt  = part_q;
        prod_nxt  = prod_q;
        valid_nxt = 1'b0;

        // Sign-extended multiplicand weighted by the current bit position.
        // The multiplier's MSB carries negative weight in two's complement,
        // so that step subtracts instead of adding.
        term = PW'(a_q) <<< cnt_q;
        sum  = part_q;
        if (b_q[cnt_q]) begin
            sum = (cnt_q == LAST) ? (part_q - term) : (part_q + term);
        end

        if (bus.clr) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            part_nxt  = '0;
            prod_nxt  = '0;
        end else if (bus.en) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_nxt     = bus.a;
                        b_nxt     = bus.b;
                        cnt_nxt   = '0;
                        part_nxt  = '0;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    part_nxt = sum;
                    cnt_nxt  = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        prod_nxt  = OWIDTH'(sum);
                        valid_nxt = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.valid = valid_q;
    assign bus.prod  = prod_q;
endmodule

// File: tb/tb_serial_mul.sv
// tb_serial_mul: directed plus randomized bench for serial_mul. Expected
// products come from plain integer multiplication; expected timing is
// IWIDTH enabled edges from the start edge.
module tb_serial_mul;
    localparam int IW = 16;
    localparam int OW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_mul_if #(.IWIDTH(IW), .OWIDTH(OW)) bus();

    serial_mul #(.IWIDTH(IW), .OWIDTH(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int start_cyc  = 0;
    int prev_start = 0;

    function automatic logic signed [63:0] ref_prod(input logic signed [IW-1:0] x,
                                                    input logic signed [IW-1:0] y);
        longint p;
        p = longint'(x) * longint'(y);
        return p;
    endfunction

    function automatic logic signed [63:0] prod64();
        logic signed [63:0] v;
        v = bus.prod;
        return v;
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic signed [IW-1:0] x, input logic signed [IW-1:0] y);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        tick();
        bus.start = 1'b0;
        bus.a     = IW'($urandom);
        bus.b     = IW'($urandom);
        start_cyc = cyc;
    endtask

    // Runs until valid, optionally stalling en and/or pulsing a stray start.
    task automatic await_done(input int stall_at, input int stall_len, input int restart_at,
                              output int lat, output int edges, output logic seen);
        logic signed [63:0] held;
        int   stalled;
        logic en_now;
        logic stall_bad;
        lat = 0; edges = 0; seen = 1'b0; stalled = 0; stall_bad = 1'b0;
        while (!seen && edges < 80) begin
            en_now    = !(stall_len > 0 && lat == stall_at && stalled < stall_len);
            bus.en    = en_now;
            bus.start = (restart_at > 0 && lat == restart_at && en_now);
            if (bus.start) begin
                bus.a = 16'sd1;
                bus.b = 16'sd1;
            end
            held = prod64();
            tick();
            edges++;
            bus.start = 1'b0;
            if (en_now) begin
                lat++;
            end else begin
                stalled++;
                if (bus.busy !== 1'b1 || prod64() !== held) stall_bad = 1'b1;
            end
            seen = (bus.valid === 1'b1);
        end
        bus.en = 1'b1;
        if (stall_len > 0) check("stall_hold", stall_bad, 0);
    endtask

    task automatic mul_check(input string tag, input logic signed [IW-1:0] x,
                             input logic signed [IW-1:0] y, input int stall_at,
                             input int stall_len, input int restart_at);
        int   lat;
        int   edges;
        logic seen;
        await_done(stall_at, stall_len, restart_at, lat, edges, seen);
        check({tag, "_valid"}, seen, 1);
        check({tag, "_latency"}, lat, IW);
        check({tag, "_edges"}, edges, IW + stall_len);
        check({tag, "_prod"}, prod64(), ref_prod(x, y));
        check({tag, "_busy_done"}, bus.busy, 0);
    endtask

    task automatic watch_quiet(input string tag, input int n);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        logic signed [IW-1:0] rx;
        logic signed [IW-1:0] ry;
        int sa;
        int sl;

        bus.en = 1'b1; bus.clr = 1'b0; bus.start = 1'b0;
        bus.a = '0; bus.b = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_prod", prod64(), 0);

        // Basic product, then the output must hold with valid low.
        issue(16'sd3, 16'sd5);
        mul_check("m3x5", 16'sd3, 16'sd5, 0, 0, 0);
        tick();
        check("m3x5_valid_drop", bus.valid, 0);
        check("m3x5_hold", prod64(), 15);
        repeat (2) tick();
        check("m3x5_hold2", prod64(), 15);

        // Back-to-back starts issued in the valid cycle.
        issue(-16'sd3, 16'sd5);
        prev_start = start_cyc;
        mul_check("mneg", -16'sd3, 16'sd5, 0, 0, 0);
        issue(16'sh8000, 16'sh8000);
        check("spacing1", start_cyc - prev_start, IW + 1);
        prev_start = start_cyc;
        mul_check("mminsq", 16'sh8000, 16'sh8000, 0, 0, 0);
        check("mminsq_const", prod64(), 64'sd1073741824);
        issue(16'sd32767, 16'sh8000);
        check("spacing2", start_cyc - prev_start, IW + 1);
        mul_check("mmaxmin", 16'sd32767, 16'sh8000, 0, 0, 0);
        check("mmaxmin_const", prod64(), -64'sd1073709056);

        // Five stalled cycles mid-run.
        issue(16'sd100, -16'sd7);
        mul_check("mstall", 16'sd100, -16'sd7, 6, 5, 0);

        // Stray start while busy is dropped, not queued.
        issue(16'sd9, 16'sd9);
        mul_check("mrestart", 16'sd9, 16'sd9, 0, 0, 3);
        watch_quiet("restart_no_second", 20);

        // Synchronous clear mid-run.
        issue(16'sd12, 16'sd12);
        repeat (7) tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("clr_busy", bus.busy, 0);
        check("clr_valid", bus.valid, 0);
        check("clr_prod", prod64(), 0);
        watch_quiet("clr_no_valid", 20);
        issue(16'sd2, -16'sd2);
        mul_check("mafterclr", 16'sd2, -16'sd2, 0, 0, 0);

        // Asynchronous reset mid-run, checked between clock edges.
        issue(16'sd50, 16'sd50);
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_valid", bus.valid, 0);
        check("arst_prod", prod64(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        watch_quiet("arst_no_valid", 20);
        issue(-16'sd1, -16'sd1);
        mul_check("mafterrst", -16'sd1, -16'sd1, 0, 0, 0);

        // Random operands, some runs with random stalls.
        for (int k = 0; k < 12; k++) begin
            rx = IW'($urandom);
            ry = IW'($urandom);
            sa = 0;
            sl = 0;
            if ($urandom_range(0, 1) == 1) begin
                sa = int'($urandom_range(1, IW - 2));
                sl = int'($urandom_range(1, 4));
            end
            issue(rx, ry);
            mul_check("mrand", rx, ry, sa, sl, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
